// File: rtl/msrv32_pc_sequencer.sv
// Fetch-stage PC sequencer: picks the next fetch address, holds the architectural PC, and freezes on misaligned targets.
// Define MSRV32_RVC_ALIGN_EN to accept halfword-aligned control-transfer targets (no misaligned trap).
module msrv32_pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [XLEN-1:0] iadder_in,
  input  logic            branch_taken_in,
  input  logic [1:0]      pc_src_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            ahb_ready_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic [XLEN-1:0] i_addr_out,
  output logic            misaligned_instr_out,
  output logic            flush_out
);

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_TRAP_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SRC_BOOT   = 2'b00;
  localparam logic [1:0] SRC_EPC    = 2'b01;
  localparam logic [1:0] SRC_TRAP   = 2'b10;
  localparam logic [1:0] SRC_NORMAL = 2'b11;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_flush;
  logic            w_flush_nxt;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus_4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  // JALR rule: bit 0 of the target is always discarded.
  assign w_target    = iadder_in & {{(XLEN-1){1'b1}}, 1'b0};
  assign w_pc_plus_4 = r_pc + 32'd4;

`ifdef MSRV32_RVC_ALIGN_EN
  assign w_misaligned = 1'b0;
`else
  assign w_misaligned = (r_state == ST_RUN) && (pc_src_in == SRC_NORMAL) &&
                        branch_taken_in && w_target[1];
`endif

  always_comb begin
    w_next_pc = w_pc_plus_4;
    if (r_state == ST_BOOT)
      w_next_pc = BOOT_ADDR;
    else if (pc_src_in == SRC_TRAP)
      w_next_pc = trap_address_in;
    else if (pc_src_in == SRC_EPC)
      w_next_pc = epc_in;
    else if (pc_src_in == SRC_BOOT)
      w_next_pc = BOOT_ADDR;
    else if (branch_taken_in && !w_misaligned)
      w_next_pc = w_target;
  end

  // A stalled bus freezes every register, including the flush flag.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flush_nxt = r_flush;
    if (ahb_ready_in) begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = BOOT_ADDR;
          w_flush_nxt = 1'b1;
        end
        ST_RUN: begin
          if (w_misaligned) begin
            w_state_nxt = ST_TRAP_WAIT;
            w_flush_nxt = 1'b0;
          end else begin
            w_pc_nxt    = w_next_pc;
            w_flush_nxt = (pc_src_in != SRC_NORMAL) || branch_taken_in;
          end
        end
        ST_TRAP_WAIT: begin
          if (pc_src_in == SRC_TRAP) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = trap_address_in;
            w_flush_nxt = 1'b1;
          end else begin
            w_flush_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = ST_BOOT;
          w_pc_nxt    = BOOT_ADDR;
          w_flush_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_BOOT;
      r_pc    <= BOOT_ADDR;
      r_flush <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  // The misaligned flag is sticky for as long as fetch is frozen in TRAP_WAIT.
  assign pc_out               = r_pc;
  assign pc_plus_4_out        = w_pc_plus_4;
  assign flush_out            = r_flush;
  assign i_addr_out           = (r_state == ST_TRAP_WAIT) ? r_pc : w_next_pc;
  assign misaligned_instr_out = w_misaligned || (r_state == ST_TRAP_WAIT);

endmodule

// File: tb/tb_msrv32_pc_sequencer.sv
// Directed testbench for msrv32_pc_sequencer with hand-computed expectations (BOOT_ADDR = 0).
module tb_msrv32_pc_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] iadder_in;
  logic        branch_taken_in;
  logic [1:0]  pc_src_in;
  logic [31:0] epc_in;
  logic [31:0] trap_address_in;
  logic        ahb_ready_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4_out;
  logic [31:0] i_addr_out;
  logic        misaligned_instr_out;
  logic        flush_out;

  int n_checks = 0;
  int n_fail   = 0;

  msrv32_pc_sequencer dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .iadder_in            (iadder_in),
    .branch_taken_in      (branch_taken_in),
    .pc_src_in            (pc_src_in),
    .epc_in               (epc_in),
    .trap_address_in      (trap_address_in),
    .ahb_ready_in         (ahb_ready_in),
    .pc_out               (pc_out),
    .pc_plus_4_out        (pc_plus_4_out),
    .i_addr_out           (i_addr_out),
    .misaligned_instr_out (misaligned_instr_out),
    .flush_out            (flush_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; ahb_ready_in = 1'b1; pc_src_in = 2'b11; branch_taken_in = 1'b0;
    iadder_in = 32'h0; epc_in = 32'h0; trap_address_in = 32'h0;
    #12;
    n_checks++; if (pc_out !== 32'h0) begin $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0); n_fail++; end
    n_checks++; if (flush_out !== 1'b1) begin $display("FAIL reset_flush: got %b expected 1", flush_out); n_fail++; end
    n_checks++; if (i_addr_out !== 32'h0) begin $display("FAIL reset_iaddr: got %h expected %h", i_addr_out, 32'h0); n_fail++; end
    n_checks++; if (misaligned_instr_out !== 1'b0) begin $display("FAIL reset_mis: got %b expected 0", misaligned_instr_out); n_fail++; end
    rst_n_in = 1'b1;
    step();
    n_checks++; if (pc_out !== 32'h0) begin $display("FAIL boot_pc: got %h expected %h", pc_out, 32'h0); n_fail++; end
    n_checks++; if (flush_out !== 1'b1) begin $display("FAIL boot_flush: got %b expected 1", flush_out); n_fail++; end
    step();
    n_checks++; if (pc_out !== 32'h4) begin $display("FAIL seq_pc4: got %h expected %h", pc_out, 32'h4); n_fail++; end
    n_checks++; if (flush_out !== 1'b0) begin $display("FAIL seq_flush: got %b expected 0", flush_out); n_fail++; end
    step();
    n_checks++; if (pc_out !== 32'h8) begin $display("FAIL seq_pc8: got %h expected %h", pc_out, 32'h8); n_fail++; end
    n_checks++; if (i_addr_out !== 32'hC) begin $display("FAIL seq_iaddr: got %h expected %h", i_addr_out, 32'hC); n_fail++; end
  endtask

  task automatic test_branch();
    pc_src_in = 2'b10; trap_address_in = 32'h100;
    step();
    n_checks++; if (pc_out !== 32'h100) begin $display("FAIL br_setup_pc: got %h expected %h", pc_out, 32'h100); n_fail++; end
    pc_src_in = 2'b11; branch_taken_in = 1'b1; iadder_in = 32'h0000_0205;
    #1;
    n_checks++; if (i_addr_out !== 32'h204) begin $display("FAIL br_iaddr: got %h expected %h", i_addr_out, 32'h204); n_fail++; end
    n_checks++; if (misaligned_instr_out !== 1'b0) begin $display("FAIL br_mis: got %b expected 0", misaligned_instr_out); n_fail++; end
    step();
    n_checks++; if (pc_out !== 32'h204) begin $display("FAIL br_pc: got %h expected %h", pc_out, 32'h204); n_fail++; end
    n_checks++; if (flush_out !== 1'b1) begin $display("FAIL br_flush: got %b expected 1", flush_out); n_fail++; end
    branch_taken_in = 1'b0;
    step();
    n_checks++; if (pc_out !== 32'h208) begin $display("FAIL br_after_pc: got %h expected %h", pc_out, 32'h208); n_fail++; end
    n_checks++; if (flush_out !== 1'b0) begin $display("FAIL br_after_flush: got %b expected 0", flush_out); n_fail++; end
  endtask

  task automatic test_misaligned();
    branch_taken_in = 1'b1; iadder_in = 32'h0000_0102;
`ifdef MSRV32_RVC_ALIGN_EN
    #1;
    n_checks++; if (misaligned_instr_out !== 1'b0) begin $display("FAIL rvc_mis: got %b expected 0", misaligned_instr_out); n_fail++; end
    step();
    n_checks++; if (pc_out !== 32'h102) begin $display("FAIL rvc_pc: got %h expected %h", pc_out, 32'h102); n_fail++; end
    branch_taken_in = 1'b0;
`else
    #1;
    n_checks++; if (misaligned_instr_out !== 1'b1) begin $display("FAIL mis_flag: got %b expected 1", misaligned_instr_out); n_fail++; end
    step();
    branch_taken_in = 1'b0;
    #1;
    n_checks++; if (pc_out !== 32'h208) begin $display("FAIL mis_hold_pc: got %h expected %h", pc_out, 32'h208); n_fail++; end
    n_checks++; if (misaligned_instr_out !== 1'b1) begin $display("FAIL mis_sticky: got %b expected 1", misaligned_instr_out); n_fail++; end
    n_checks++; if (i_addr_out !== 32'h208) begin $display("FAIL mis_iaddr: got %h expected %h", i_addr_out, 32'h208); n_fail++; end
    pc_src_in = 2'b01; epc_in = 32'h500;
    step();
    n_checks++; if (pc_out !== 32'h208) begin $display("FAIL mis_wait_pc: got %h expected %h", pc_out, 32'h208); n_fail++; end
`endif
    pc_src_in = 2'b10; trap_address_in = 32'h800;
    step();
    n_checks++; if (pc_out !== 32'h800) begin $display("FAIL trap_pc: got %h expected %h", pc_out, 32'h800); n_fail++; end
    n_checks++; if (misaligned_instr_out !== 1'b0) begin $display("FAIL trap_mis_clr: got %b expected 0", misaligned_instr_out); n_fail++; end
    n_checks++; if (flush_out !== 1'b1) begin $display("FAIL trap_flush: got %b expected 1", flush_out); n_fail++; end
  endtask

  task automatic test_stall();
    pc_src_in = 2'b10; trap_address_in = 32'h40; branch_taken_in = 1'b1; iadder_in = 32'h0000_0102;
    #1;
    n_checks++; if (misaligned_instr_out !== 1'b0) begin $display("FAIL trap_wins_mis: got %b expected 0", misaligned_instr_out); n_fail++; end
    n_checks++; if (i_addr_out !== 32'h40) begin $display("FAIL trap_wins_iaddr: got %h expected %h", i_addr_out, 32'h40); n_fail++; end
    step();
    pc_src_in = 2'b11; iadder_in = 32'h80; ahb_ready_in = 1'b0;
    #1;
    n_checks++; if (i_addr_out !== 32'h80) begin $display("FAIL stall_iaddr: got %h expected %h", i_addr_out, 32'h80); n_fail++; end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pc_out !== 32'h40) begin $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc_out, 32'h40); n_fail++; end
    end
    n_checks++; if (flush_out !== 1'b1) begin $display("FAIL stall_flush_hold: got %b expected 1", flush_out); n_fail++; end
    ahb_ready_in = 1'b1;
    step();
    n_checks++; if (pc_out !== 32'h80) begin $display("FAIL stall_release_pc: got %h expected %h", pc_out, 32'h80); n_fail++; end
    branch_taken_in = 1'b0;
  endtask

  task automatic test_epc_wrap();
    pc_src_in = 2'b01; epc_in = 32'h3C;
    step();
    n_checks++; if (pc_out !== 32'h3C) begin $display("FAIL epc_pc: got %h expected %h", pc_out, 32'h3C); n_fail++; end
    n_checks++; if (flush_out !== 1'b1) begin $display("FAIL epc_flush: got %b expected 1", flush_out); n_fail++; end
    pc_src_in = 2'b10; trap_address_in = 32'hFFFF_FFFC;
    step();
    pc_src_in = 2'b11;
    #1;
    n_checks++; if (pc_plus_4_out !== 32'h0) begin $display("FAIL wrap_plus4: got %h expected %h", pc_plus_4_out, 32'h0); n_fail++; end
    n_checks++; if (i_addr_out !== 32'h0) begin $display("FAIL wrap_iaddr: got %h expected %h", i_addr_out, 32'h0); n_fail++; end
    step();
    n_checks++; if (pc_out !== 32'h0) begin $display("FAIL wrap_pc: got %h expected %h", pc_out, 32'h0); n_fail++; end
    n_checks++; if (flush_out !== 1'b0) begin $display("FAIL wrap_flush: got %b expected 0", flush_out); n_fail++; end
  endtask

  task automatic test_async_reset();
    pc_src_in = 2'b10; trap_address_in = 32'h300;
    step();
    pc_src_in = 2'b11; branch_taken_in = 1'b1; iadder_in = 32'h0000_0102;
    step();
`ifndef MSRV32_RVC_ALIGN_EN
    n_checks++; if (pc_out !== 32'h300) begin $display("FAIL ar_wait_pc: got %h expected %h", pc_out, 32'h300); n_fail++; end
    n_checks++; if (misaligned_instr_out !== 1'b1) begin $display("FAIL ar_wait_mis: got %b expected 1", misaligned_instr_out); n_fail++; end
`endif
    #2;
    rst_n_in = 1'b0;
    #1;
    n_checks++; if (pc_out !== 32'h0) begin $display("FAIL ar_pc: got %h expected %h", pc_out, 32'h0); n_fail++; end
    n_checks++; if (misaligned_instr_out !== 1'b0) begin $display("FAIL ar_mis: got %b expected 0", misaligned_instr_out); n_fail++; end
    n_checks++; if (i_addr_out !== 32'h0) begin $display("FAIL ar_iaddr: got %h expected %h", i_addr_out, 32'h0); n_fail++; end
    n_checks++; if (flush_out !== 1'b1) begin $display("FAIL ar_flush: got %b expected 1", flush_out); n_fail++; end
    branch_taken_in = 1'b0;
    step();
    rst_n_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_misaligned();
    test_stall();
    test_epc_wrap();
    test_async_reset();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_pc_sequencer.md
Name: msrv32_pc_sequencer

Overview:
- Consumer end of the immediate-adder path. Takes the computed jump/branch target (`iadder_in`) and selects the next fetch address among boot vector, trap vector, EPC, branch/jump target and PC+4.
- Holds the architectural PC register and drives the instruction-fetch address.
- Detects misaligned control-transfer targets and freezes fetch until the trap is taken.
- Sits between the immediate adder / branch unit and the instruction bus interface in the fetch stage.

Parameters:
- BOOT_ADDR, 32'h0000_0000, fetch address presented after reset.
- XLEN, 32, address/data width. Only 32 is supported.

Ports:
- clk_in  input  1  core clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- iadder_in  input  32  jump/branch target from the immediate adder.
- branch_taken_in  input  1  1 = take `iadder_in` (JAL, JALR, or taken branch).
- pc_src_in  input  2  next-PC source: 00 boot, 01 EPC (mret), 10 trap vector, 11 normal operation.
- epc_in  input  32  return address from the CSR file.
- trap_address_in  input  32  trap vector from the CSR file.
- ahb_ready_in  input  1  instruction bus ready; 0 = stall.
- pc_out  output  32  PC of the instruction currently in execute (registered).
- pc_plus_4_out  output  32  `pc_out + 4`, combinational; used as the link value.
- i_addr_out  output  32  fetch address for the next cycle (combinational `next_pc`).
- misaligned_instr_out  output  1  the selected target is misaligned.
- flush_out  output  1  registered; kill the instruction fetched this cycle.

Behaviour:
Reset
- `rst_n_in` low forces asynchronously: state = BOOT, `pc_out` = BOOT_ADDR, `flush_out` = 1.
- Combinational outputs during reset: `i_addr_out` = BOOT_ADDR, `misaligned_instr_out` = 0.

Target formation
- `target = {iadder_in[31:1], 1'b0}`: bit 0 is always cleared (JALR rule).
- `misaligned = branch_taken_in & target[1]`, evaluated only when `pc_src_in` = 11.

next_pc mux, priority order
1. State BOOT → BOOT_ADDR.
2. `pc_src_in` = 10 → `trap_address_in`.
3. `pc_src_in` = 01 → `epc_in`.
4. `pc_src_in` = 00 → BOOT_ADDR.
5. `pc_src_in` = 11 and `branch_taken_in` and not misaligned → `target`.
6. Otherwise → `pc_out + 4`.

Output relationships
- `i_addr_out` = `next_pc`, except in state TRAP_WAIT, where it holds `pc_out`.
- Arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0, with no flag.

State machine (3 states)
- BOOT
  - Entered from reset.
  - Next edge with `ahb_ready_in` = 1: `pc_out` ← BOOT_ADDR, go to RUN.
- RUN
  - Each edge with `ahb_ready_in` = 1: `pc_out` ← `next_pc`.
  - If `misaligned_instr_out` = 1 on that edge: go to TRAP_WAIT and do not load `pc_out`.
- TRAP_WAIT
  - `pc_out` held and `i_addr_out` = `pc_out`.
  - `misaligned_instr_out` stays 1 (sticky).
  - When `pc_src_in` = 10 and `ahb_ready_in` = 1: `pc_out` ← `trap_address_in`, clear the sticky flag, go to RUN.
  - Any other `pc_src_in` value: remain in TRAP_WAIT.

Stall and flush
- `ahb_ready_in` = 0: all registers hold and `flush_out` holds; no state change.
- `flush_out` is registered. It is 1 for the cycle after any edge that loaded a non-sequential `next_pc` (taken branch, trap, EPC, boot); otherwise 0.
- Latency: `i_addr_out` is same-cycle combinational; `pc_out` and `flush_out` update 1 cycle later.

Simultaneous events
- Trap (`pc_src_in` = 10) with `branch_taken_in` = 1: trap wins, no misaligned flag.
- Misaligned with `ahb_ready_in` = 0: flag asserted combinationally; state change deferred until ready.
- Reset mid-stall or in TRAP_WAIT: immediate return to BOOT.

Optional Feature:
- Macro: `MSRV32_RVC_ALIGN_EN`.
- Defined: halfword alignment is legal.
  - `misaligned` is tied to 0.
  - TRAP_WAIT is unreachable.
  - `target[1]` passes through.
- Undefined: word alignment is enforced as described in Behaviour.

Test Plan:
1. Reset release, `ahb_ready_in` = 1, `pc_src_in` = 11, no branch, BOOT_ADDR = 0
   → `pc_out` 0, 4, 8 on successive edges; `flush_out` 1 then 0.
2. `pc_out` = 0x100, `branch_taken_in` = 1, `iadder_in` = 0x0000_0205
   → `i_addr_out` = 0x204, next `pc_out` = 0x204, `flush_out` = 1 for one cycle.
3. `branch_taken_in` = 1, `iadder_in` = 0x0000_0102
   → `misaligned_instr_out` = 1, `pc_out` holds; then `pc_src_in` = 10 with `trap_address_in` = 0x800 → `pc_out` = 0x800 and flag clears.
   - With `MSRV32_RVC_ALIGN_EN` defined: `pc_out` = 0x102 and no flag.
4. `ahb_ready_in` = 0 for 3 cycles with `pc_out` = 0x40 and a taken branch pending
   → `pc_out` stays 0x40; on ready it loads the target.
5. `pc_src_in` = 01, `epc_in` = 0x3C; and separately `pc_out` = 0xFFFF_FFFC sequential
   → `pc_out` = 0x3C; wrap case gives `pc_out` = 0x0.
6. Assert `rst_n_in` asynchronously mid-cycle while in TRAP_WAIT
   → `pc_out` = BOOT_ADDR and `misaligned_instr_out` = 0 immediately, with no clock edge.
